// File: rtl/cnn_conv3x3_stream.sv
// Streaming 3x3 valid-mode convolution: two line buffers, 2-stage MAC, bias/shift/ReLU/saturate.
// Defining CNN_CONV_MAXPOOL_EN adds a 2x2 stride-2 max pool on the ReLU output.
module cnn_conv3x3_stream #(
    parameter int DATA_WIDTH          = 8,
    parameter int COEF_WIDTH          = 8,
    parameter int ACC_WIDTH           = 24,
    parameter int MAX_IMAGE_SIZE      = 512,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9
) (
    input  logic                           data_clk,
    input  logic                           data_rst_n,
    input  logic                           cfg_we,
    input  logic [3:0]                     cfg_addr,
    input  logic [ACC_WIDTH-1:0]           cfg_wdata,
    input  logic [MAX_IMAGE_SIZE_LOG2:0]   image_size,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);
    localparam int NW = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int PW = DATA_WIDTH + COEF_WIDTH + 1;
    localparam logic [NW-1:0] MAX_N = NW'(MAX_IMAGE_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic signed [COEF_WIDTH-1:0] r_w [9];
    logic signed [ACC_WIDTH-1:0]  r_bias;
    logic [4:0]                   r_shift;

    logic [NW-1:0] r_n, r_row, r_col, w_nm1;
    logic          r_in_done, r_cfg_err;
    logic          w_start_ok, w_accept, w_stall, w_last_px, w_win_ok, w_frame_end;

    logic [DATA_WIDTH-1:0]          r_lb0 [MAX_IMAGE_SIZE];
    logic [DATA_WIDTH-1:0]          r_lb1 [MAX_IMAGE_SIZE];
    logic [DATA_WIDTH-1:0]          r_win [3][2];
    logic [DATA_WIDTH-1:0]          w_col [3];
    logic [DATA_WIDTH-1:0]          w_pix [9];
    logic [MAX_IMAGE_SIZE_LOG2-1:0] w_lb_idx;

    logic signed [PW-1:0]         w_prod [9];
    logic signed [PW-1:0]         r_prod [9];
    logic                         r_s1_vld;
    logic signed [ACC_WIDTH-1:0]  w_sum, w_shifted;
    logic [DATA_WIDTH-1:0]        w_relu;
    logic                         r_s2_vld;
    logic [DATA_WIDTH-1:0]        r_s2_data;

    assign w_start_ok = start && (image_size >= NW'(3)) && (image_size <= MAX_N);
    assign w_nm1      = r_n - NW'(1);
    assign w_stall    = out_valid & ~out_ready;
    assign in_ready   = (r_state == S_RUN) & ~r_in_done & ~w_stall;
    assign w_accept   = in_valid & in_ready;
    assign w_last_px  = (r_row == w_nm1) && (r_col == w_nm1);
    assign w_win_ok   = (r_row >= NW'(2)) && (r_col >= NW'(2));
    assign w_lb_idx   = r_col[MAX_IMAGE_SIZE_LOG2-1:0];
    assign cfg_err    = r_cfg_err;

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (w_frame_end) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            for (int unsigned i = 0; i < 9; i++) r_w[i] <= '0;
            r_bias  <= '0;
            r_shift <= '0;
        end else if (cfg_we && r_state == S_IDLE) begin
            if (cfg_addr <= 4'd8)       r_w[cfg_addr] <= cfg_wdata[COEF_WIDTH-1:0];
            else if (cfg_addr == 4'd9)  r_bias        <= cfg_wdata;
            else if (cfg_addr == 4'd10) r_shift       <= cfg_wdata[4:0];
        end
    end

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            r_n       <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_in_done <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            if (w_start_ok) begin
                r_n       <= image_size;
                r_row     <= '0;
                r_col     <= '0;
                r_in_done <= 1'b0;
                r_cfg_err <= 1'b0;
            end else begin
                r_cfg_err <= 1'b1;
            end
        end else if (w_accept) begin
            if (r_col == w_nm1) begin
                r_col <= '0;
                if (r_row == w_nm1) r_in_done <= 1'b1;
                else                r_row     <= r_row + NW'(1);
            end else begin
                r_col <= r_col + NW'(1);
            end
        end
    end

    // Line buffers shift vertically per column; r_win holds columns c-2 and c-1 of the window.
    always_ff @(posedge data_clk) begin
        if (w_accept) begin
            r_lb0[w_lb_idx] <= w_col[1];
            r_lb1[w_lb_idx] <= in_data;
            for (int unsigned ky = 0; ky < 3; ky++) begin
                r_win[ky][0] <= r_win[ky][1];
                r_win[ky][1] <= w_col[ky];
            end
        end
    end

    always_comb begin
        w_col[0] = r_lb0[w_lb_idx];
        w_col[1] = r_lb1[w_lb_idx];
        w_col[2] = in_data;
        for (int unsigned ky = 0; ky < 3; ky++) begin
            w_pix[ky*3]     = r_win[ky][0];
            w_pix[ky*3 + 1] = r_win[ky][1];
            w_pix[ky*3 + 2] = w_col[ky];
        end
        for (int unsigned k = 0; k < 9; k++)
            w_prod[k] = PW'($signed({1'b0, w_pix[k]})) * PW'(r_w[k]);
    end

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            r_s1_vld <= 1'b0;
            for (int unsigned k = 0; k < 9; k++) r_prod[k] <= '0;
        end else if (!w_stall) begin
            r_s1_vld <= w_accept & w_win_ok;
            if (w_accept)
                for (int unsigned k = 0; k < 9; k++) r_prod[k] <= w_prod[k];
        end
    end

    always_comb begin
        w_sum = r_bias;
        for (int unsigned k = 0; k < 9; k++) w_sum = w_sum + ACC_WIDTH'(r_prod[k]);
        w_shifted = w_sum >>> r_shift;
        if (w_shifted[ACC_WIDTH-1])                    w_relu = '0;
        else if (|w_shifted[ACC_WIDTH-2:DATA_WIDTH])   w_relu = '1;
        else                                           w_relu = w_shifted[DATA_WIDTH-1:0];
    end

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
        end else if (!w_stall) begin
            r_s2_vld  <= r_s1_vld;
            r_s2_data <= w_relu;
        end
    end

`ifdef CNN_CONV_MAXPOOL_EN
    logic [NW-1:0]                  r_oc, r_or, w_pn, w_p2;
    logic [DATA_WIDTH-1:0]          r_hmax, r_p_data, w_hmax, w_pmax, w_pbuf_rd;
    logic                           r_p_vld, r_p_last, w_pool_elig;
    logic [DATA_WIDTH-1:0]          r_pbuf [MAX_IMAGE_SIZE/2];
    logic [MAX_IMAGE_SIZE_LOG2-2:0] w_pidx;

    // Even conv rows park their horizontal pair max; odd rows combine with it.
    assign w_pn        = r_n - NW'(2);
    assign w_p2        = {w_pn[NW-1:1], 1'b0};
    assign w_pool_elig = (r_or < w_p2) && (r_oc < w_p2);
    assign w_pidx      = r_oc[MAX_IMAGE_SIZE_LOG2-1:1];
    assign w_pbuf_rd   = r_pbuf[w_pidx];
    assign w_hmax      = (r_s2_data > r_hmax) ? r_s2_data : r_hmax;
    assign w_pmax      = (w_pbuf_rd > w_hmax) ? w_pbuf_rd : w_hmax;

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            r_oc     <= '0;
            r_or     <= '0;
            r_hmax   <= '0;
            r_p_vld  <= 1'b0;
            r_p_data <= '0;
            r_p_last <= 1'b0;
        end else if (r_state == S_IDLE && w_start_ok) begin
            r_oc     <= '0;
            r_or     <= '0;
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
        end else if (!w_stall) begin
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
            if (r_s2_vld) begin
                if (r_oc == w_pn - NW'(1)) begin
                    r_oc <= '0;
                    r_or <= r_or + NW'(1);
                end else begin
                    r_oc <= r_oc + NW'(1);
                end
                if (!r_oc[0]) begin
                    r_hmax <= r_s2_data;
                end else if (w_pool_elig && r_or[0]) begin
                    r_p_vld  <= 1'b1;
                    r_p_data <= w_pmax;
                    r_p_last <= (r_or == w_p2 - NW'(1)) && (r_oc == w_p2 - NW'(1));
                end
            end
        end
    end

    always_ff @(posedge data_clk) begin
        if (!w_stall && r_s2_vld && r_oc[0] && !r_or[0] && w_pool_elig)
            r_pbuf[w_pidx] <= w_hmax;
    end

    assign out_valid   = r_p_vld;
    assign out_data    = r_p_data;
    assign out_last    = r_p_last;
    // With no pooled outputs the frame ends on the final input pixel.
    assign w_frame_end = (out_valid & out_ready & out_last) | ((w_p2 == '0) & w_accept & w_last_px);
`else
    logic r_s1_last, r_s2_last;

    always_ff @(posedge data_clk or negedge data_rst_n) begin
        if (!data_rst_n) begin
            r_s1_last <= 1'b0;
            r_s2_last <= 1'b0;
        end else if (!w_stall) begin
            r_s1_last <= w_accept & w_last_px;
            r_s2_last <= r_s1_last;
        end
    end

    assign out_valid   = r_s2_vld;
    assign out_data    = r_s2_data;
    assign out_last    = r_s2_last;
    assign w_frame_end = out_valid & out_ready & out_last;
`endif

endmodule

// File: tb/tb_cnn_conv3x3_stream.sv
// Directed bench for cnn_conv3x3_stream with a behavioural scoreboard model.
// Pool expectations follow CNN_CONV_MAXPOOL_EN when defined.
module tb_cnn_conv3x3_stream;
    localparam int LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [23:0] cfg_wdata = '0;
    logic [9:0]  image_size = '0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy, done, cfg_err;

    cnn_conv3x3_stream #(
        .DATA_WIDTH(8), .COEF_WIDTH(8), .ACC_WIDTH(24),
        .MAX_IMAGE_SIZE(512), .MAX_IMAGE_SIZE_LOG2(9)
    ) dut (
        .data_clk(clk), .data_rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .image_size(image_size), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct { int data; bit last; } exp_t;
    exp_t exp_q[$];
    int   got_q[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int out_cnt = 0, first_out_cyc = -1, last_cyc = -1, done_cyc = -1;
    int hs_cyc [0:63];
    int img [0:63];
    int m_w [9];
    int m_bias = 0, m_shift = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (first_out_cyc < 0) first_out_cyc = cyc;
                got_q.push_back(out_data);
                out_cnt++;
                chk("sb_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    if (out_last) last_cyc = cyc;
                end
            end
        end
    end

    function automatic int exp_count(input int n);
`ifdef CNN_CONV_MAXPOOL_EN
        return ((n - 2) / 2) * ((n - 2) / 2);
`else
        return (n - 2) * (n - 2);
`endif
    endfunction

    function automatic void push_expected(input int n);
        int m = n - 2;
        int conv [0:63];
        int acc, v;
        exp_t e;
        for (int r = 0; r < m; r++)
            for (int c = 0; c < m; c++) begin
                acc = m_bias;
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        acc += m_w[ky*3 + kx] * img[(r + ky)*n + c + kx];
                v = acc >>> m_shift;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                conv[r*m + c] = v;
            end
`ifdef CNN_CONV_MAXPOOL_EN
        for (int i = 0; i < m / 2; i++)
            for (int j = 0; j < m / 2; j++) begin
                v = conv[2*i*m + 2*j];
                if (conv[2*i*m + 2*j + 1] > v)     v = conv[2*i*m + 2*j + 1];
                if (conv[(2*i + 1)*m + 2*j] > v)   v = conv[(2*i + 1)*m + 2*j];
                if (conv[(2*i + 1)*m + 2*j + 1] > v) v = conv[(2*i + 1)*m + 2*j + 1];
                e.data = v;
                e.last = (i == m/2 - 1) && (j == m/2 - 1);
                exp_q.push_back(e);
            end
`else
        for (int k = 0; k < m*m; k++) begin
            e.data = conv[k];
            e.last = (k == m*m - 1);
            exp_q.push_back(e);
        end
`endif
    endfunction

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = 24'(data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic write_model_cfg();
        for (int i = 0; i < 9; i++) cfg_write(i, m_w[i]);
        cfg_write(9, m_bias);
        cfg_write(10, m_shift);
    endtask

    task automatic start_frame(input int n);
        image_size = 10'(n); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int count);
        int t;
        for (int k = 0; k < count; k++) begin
            in_valid = 1'b1; in_data = 8'(img[k]);
            t = 0;
            do begin @(negedge clk); t++; end while (!in_ready && t < LIMIT);
            if (!in_ready) begin
                chk("in_ready_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
            hs_cyc[k] = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic begin_frame(input int n);
        got_q.delete(); out_cnt = 0; first_out_cyc = -1; last_cyc = -1;
        push_expected(n);
        start_frame(n);
    endtask

    task automatic finish_frame(input int n);
        int t = 0;
        do begin @(negedge clk); t++; end while (!done && t < LIMIT);
        chk("done_seen", done, 1);
        done_cyc = cyc;
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
        chk("out_count", out_cnt, exp_count(n));
        @(posedge clk); #1;
    endtask

    task automatic set_identity();
        foreach (m_w[i]) m_w[i] = 0;
        m_w[4] = 1; m_bias = 0; m_shift = 0;
        write_model_cfg();
    endtask

    initial begin
        int cnt;
        foreach (m_w[i]) m_w[i] = 0;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // identity, N=4, ramp 0..15
        set_identity();
        for (int k = 0; k < 16; k++) img[k] = k;
        begin_frame(4);
        feed(16);
        finish_frame(4);
        chk("t1_done_after_last", done_cyc - last_cyc, 1);
        chk("t1_throughput", hs_cyc[15] - hs_cyc[0], 15);
`ifdef CNN_CONV_MAXPOOL_EN
        if (got_q.size() == 1) chk("t1_pool0", got_q[0], 10);
`else
        chk("t1_latency", first_out_cyc - hs_cyc[10], 2);
        if (got_q.size() == 4) begin
            chk("t1_out0", got_q[0], 5);
            chk("t1_out1", got_q[1], 6);
            chk("t1_out2", got_q[2], 9);
            chk("t1_out3", got_q[3], 10);
        end
`endif

        // all ones, N=3, pixels 255, shift 3 -> saturates
        foreach (m_w[i]) m_w[i] = 1;
        m_bias = 0; m_shift = 3;
        write_model_cfg();
        for (int k = 0; k < 9; k++) img[k] = 255;
        begin_frame(3);
        feed(9);
        finish_frame(3);
`ifndef CNN_CONV_MAXPOOL_EN
        if (got_q.size() == 1) chk("t2_sat", got_q[0], 255);
`endif

        // negative centre weight, N=5 -> ReLU zeros
        foreach (m_w[i]) m_w[i] = 0;
        m_w[4] = -1; m_bias = 0; m_shift = 0;
        write_model_cfg();
        for (int k = 0; k < 25; k++) img[k] = $urandom_range(0, 255);
        begin_frame(5);
        feed(25);
        finish_frame(5);

        // identity, N=8 ramp, random backpressure; busy-time cfg write and start ignored
        set_identity();
        for (int k = 0; k < 64; k++) img[k] = k;
        rand_ready = 1'b1;
        begin_frame(8);
        cfg_write(4, 3);
        image_size = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        feed(64);
        finish_frame(8);
        rand_ready = 1'b0;
        chk("t4_cfg_err_clear", cfg_err, 0);

        // bad size, then reset mid-frame
        start_frame(2);
        @(negedge clk);
        chk("t5_cfg_err", cfg_err, 1);
        chk("t5_busy_idle", busy, 0);
        @(posedge clk); #1;
        set_identity();
        start_frame(5);
        @(negedge clk);
        chk("t5_cfg_err_clr", cfg_err, 0);
        chk("t5_busy_run", busy, 1);
        @(posedge clk); #1;
        for (int k = 0; k < 25; k++) img[k] = k + 100;
        feed(10);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin @(negedge clk); if (out_valid !== 1'b0) cnt++; end
        chk("t5_no_out_after_rst", cnt, 0);
        @(posedge clk); #1;
        foreach (m_w[i]) m_w[i] = 0;
        m_bias = 0; m_shift = 0;
        for (int k = 0; k < 16; k++) img[k] = k + 1;
        begin_frame(4);
        feed(16);
        finish_frame(4);

        // identity, N=6, ramp 0..35
        set_identity();
        for (int k = 0; k < 36; k++) img[k] = k;
        begin_frame(6);
        feed(36);
        finish_frame(6);
`ifdef CNN_CONV_MAXPOOL_EN
        if (got_q.size() == 4) begin
            chk("t6_pool0", got_q[0], 14);
            chk("t6_pool1", got_q[1], 16);
            chk("t6_pool2", got_q[2], 26);
            chk("t6_pool3", got_q[3], 28);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
